smpl_iter_multi: RTL and testbench

//  Transmit side of the per-lane sample stream that the sample-count and hash scoreboards consume.

---
 rtl/smpl_iter_multi_pkg.sv | 36 +++
 rtl/smpl_iter_multi_lane_gen.sv | 30 +++
 rtl/smpl_iter_multi.sv | 170 +++++++++++++++++
 tb/tb_smpl_iter_multi.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/smpl_iter_multi_pkg.sv
// Shared types and helpers for the sample iterator and its bbox / hash_jitter neighbours.
package smpl_iter_multi_pkg;

    localparam int DEF_SIGFIG = 24;
    localparam int DEF_RADIX  = 10;
    localparam int DEF_VERTS  = 3;
    localparam int DEF_AXIS   = 3;
    localparam int DEF_COLORS = 3;
    localparam int DEF_SAMPS  = 4;

    typedef enum logic [0:0] {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_t;

    typedef logic [DEF_AXIS-1:0][DEF_SIGFIG-1:0]            vertex_t;
    typedef vertex_t [DEF_VERTS-1:0]                        tri_t;
    typedef logic [DEF_COLORS-1:0][DEF_SIGFIG-1:0]          color_t;
    typedef logic [1:0][1:0][DEF_SIGFIG-1:0]                box_t;
    typedef logic [1:0][DEF_SAMPS-1:0][DEF_SIGFIG-1:0]      sample_t;
    typedef logic signed [DEF_SIGFIG:0]                     coord_t;

    // Subsample step in fixed point: one pixel divided by the per-axis MSAA factor.
    function automatic coord_t ss_step(input logic [3:0] sub_sample, input int radix);
        int lg2;
        case (sub_sample)
            4'b0001: lg2 = 3;
            4'b0010: lg2 = 2;
            4'b0100: lg2 = 1;
            4'b1000: lg2 = 0;
            default: lg2 = 0;
        endcase
        return {{DEF_SIGFIG{1'b0}}, 1'b1} << (radix - lg2);
    endfunction

endpackage

// File: rtl/smpl_iter_multi_lane_gen.sv
// Combinational lane generator: lane x positions, lane valid mask and row-end flag.
module smpl_lane_gen #(
    parameter int SIGFIG = 24,
    parameter int SAMPS  = 4
) (
    input  logic signed [SIGFIG:0]              cur_x,
    input  logic signed [SIGFIG:0]              step,
    input  logic signed [SIGFIG:0]              ur_x,
    output logic [SAMPS-1:0][SIGFIG-1:0]        lane_x,
    output logic [SAMPS-1:0]                    lane_valid,
    output logic signed [SIGFIG:0]              next_x,
    output logic                                row_end
);

    // Walk the lanes with a running sum; the sum after the last lane is the next group start.
    always_comb begin
        logic signed [SIGFIG:0] acc;
        acc        = cur_x;
        lane_x     = '0;
        lane_valid = '0;
        for (int i = 0; i < SAMPS; i++) begin
            lane_x[i]     = acc[SIGFIG-1:0];
            lane_valid[i] = (acc <= ur_x);
            acc           = acc + step;
        end
        next_x  = acc;
        row_end = (acc > ur_x);
    end

endmodule

// File: rtl/smpl_iter_multi.sv
// Sample iterator: walks a triangle bounding box emitting SAMPS adjacent samples per cycle.
module smpl_iter_multi
    import smpl_iter_multi_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]           color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]             box_R13S,
    input  logic                                    validTri_R13H,
    input  logic [3:0]                              subSample_RnnnnU,
    input  logic                                    halt_in_RnnnnL,
    output logic                                    halt_RnnnnL,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]           color_R14U,
    output logic [1:0][SAMPS-1:0][SIGFIG-1:0]       sample_R14S,
    output logic [SAMPS-1:0]                        validSamp_R14H
);

    state_t                                 state_q, state_d;
    logic                                   halt_q, halt_d;
    logic signed [SIGFIG:0]                 cur_x_q, cur_x_d;
    logic signed [SIGFIG:0]                 cur_y_q, cur_y_d;
    logic signed [SIGFIG:0]                 step_q, step_d;
    logic signed [SIGFIG:0]                 ll_x_q, ll_x_d;
    logic signed [SIGFIG:0]                 ur_x_q, ur_x_d;
    logic signed [SIGFIG:0]                 ur_y_q, ur_y_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
    logic [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_q, sample_d;
    logic [SAMPS-1:0]                       valid_q, valid_d;

    logic [SAMPS-1:0][SIGFIG-1:0]           lane_x_s;
    logic [SAMPS-1:0]                       lane_valid_s;
    logic signed [SIGFIG:0]                 next_x_s;
    logic                                   row_end_s;
    logic signed [SIGFIG:0]                 next_y_s;
    logic                                   last_group_s;

    smpl_lane_gen #(
        .SIGFIG (SIGFIG),
        .SAMPS  (SAMPS)
    ) u_lane_gen (
        .cur_x      (cur_x_q),
        .step       (step_q),
        .ur_x       (ur_x_q),
        .lane_x     (lane_x_s),
        .lane_valid (lane_valid_s),
        .next_x     (next_x_s),
        .row_end    (row_end_s)
    );

    // The group on the iterator is the last one when its row ends and no further row fits.
    assign next_y_s     = cur_y_q + step_q;
    assign last_group_s = row_end_s && (next_y_s > ur_y_q);

    // Next-state logic: accept a triangle in WAIT, emit one group per unstalled TEST cycle.
    always_comb begin
        state_d  = state_q;
        halt_d   = halt_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        step_d   = step_q;
        ll_x_d   = ll_x_q;
        ur_x_d   = ur_x_q;
        ur_y_d   = ur_y_q;
        tri_d    = tri_q;
        color_d  = color_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        case (state_q)
            WAIT_STATE: begin
                halt_d = 1'b1;
                if (halt_in_RnnnnL) begin
                    valid_d = '0;
                    if (validTri_R13H) begin
                        tri_d   = tri_R13S;
                        color_d = color_R13U;
                        ll_x_d  = {box_R13S[0][0][SIGFIG-1], box_R13S[0][0]};
                        ur_x_d  = {box_R13S[1][0][SIGFIG-1], box_R13S[1][0]};
                        ur_y_d  = {box_R13S[1][1][SIGFIG-1], box_R13S[1][1]};
                        cur_x_d = {box_R13S[0][0][SIGFIG-1], box_R13S[0][0]};
                        cur_y_d = {box_R13S[0][1][SIGFIG-1], box_R13S[0][1]};
                        step_d  = (SIGFIG+1)'(ss_step(subSample_RnnnnU, RADIX));
                        state_d = TEST_STATE;
                        halt_d  = 1'b0;
                    end else begin
                        state_d = WAIT_STATE;
                    end
                end else begin
                    valid_d = valid_q;
                end
            end
            TEST_STATE: begin
                halt_d = 1'b0;
                if (halt_in_RnnnnL) begin
                    for (int i = 0; i < SAMPS; i++) begin
                        sample_d[0][i] = lane_x_s[i];
                        sample_d[1][i] = cur_y_q[SIGFIG-1:0];
                    end
                    valid_d = lane_valid_s;
                    if (row_end_s) begin
                        cur_x_d = ll_x_q;
                        cur_y_d = next_y_s;
                    end else begin
                        cur_x_d = next_x_s;
                    end
                    if (last_group_s) begin
                        state_d = WAIT_STATE;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = TEST_STATE;
                    end
                end else begin
                    state_d = TEST_STATE;
                end
            end
            default: begin
                state_d = WAIT_STATE;
                halt_d  = 1'b1;
                valid_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_STATE;
            halt_q   <= 1'b1;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            step_q   <= '0;
            ll_x_q   <= '0;
            ur_x_q   <= '0;
            ur_y_q   <= '0;
            tri_q    <= '0;
            color_q  <= '0;
            sample_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            halt_q   <= halt_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            step_q   <= step_d;
            ll_x_q   <= ll_x_d;
            ur_x_q   <= ur_x_d;
            ur_y_q   <= ur_y_d;
            tri_q    <= tri_d;
            color_q  <= color_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign halt_RnnnnL    = halt_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = sample_q;
    assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_smpl_iter_multi.sv
// Directed self-checking bench for smpl_iter_multi (RADIX=10, SAMPS=4).
module tb_smpl_iter_multi;

    logic                       clk;
    logic                       rst;
    logic [2:0][2:0][23:0]      tri_R13S;
    logic [2:0][23:0]           color_R13U;
    logic [1:0][1:0][23:0]      box_R13S;
    logic                       validTri_R13H;
    logic [3:0]                 subSample_RnnnnU;
    logic                       halt_in_RnnnnL;
    logic                       halt_RnnnnL;
    logic [2:0][2:0][23:0]      tri_R14S;
    logic [2:0][23:0]           color_R14U;
    logic [1:0][3:0][23:0]      sample_R14S;
    logic [3:0]                 validSamp_R14H;

    int pass_cnt  = 0;
    int total_cnt = 0;

    smpl_iter_multi dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_in_RnnnnL   (halt_in_RnnnnL),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tri(input logic [23:0] llx, input logic [23:0] lly,
                             input logic [23:0] urx, input logic [23:0] ury,
                             input logic [3:0] ss, input logic [23:0] tag);
        box_R13S[0][0]   = llx;
        box_R13S[0][1]   = lly;
        box_R13S[1][0]   = urx;
        box_R13S[1][1]   = ury;
        subSample_RnnnnU = ss;
        tri_R13S         = {9{tag}};
        color_R13U       = {3{tag + 24'd1}};
        validTri_R13H    = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total_cnt++; if (halt_RnnnnL !== 1'b1) $display("FAIL reset_halt got=%b exp=1", halt_RnnnnL); else pass_cnt++;
        total_cnt++; if (validSamp_R14H !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", validSamp_R14H); else pass_cnt++;
        total_cnt++; if (sample_R14S !== '0) $display("FAIL reset_sample got=%h exp=0", sample_R14S); else pass_cnt++;
        total_cnt++; if (tri_R14S !== '0 || color_R14U !== '0) $display("FAIL reset_tri_color got=%h/%h exp=0", tri_R14S, color_R14U); else pass_cnt++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_1x_two_rows;
        logic [8:0][23:0] exp_tri;
        exp_tri = {9{24'h000111}};
        drive_tri(24'd0, 24'd0, 24'd3072, 24'd1024, 4'b1000, 24'h000111);
        tick;
        validTri_R13H = 1'b0;
        total_cnt++; if (halt_RnnnnL !== 1'b0 || validSamp_R14H !== 4'b0000) $display("FAIL two_rows_accept halt=%b valid=%b exp=0/0000", halt_RnnnnL, validSamp_R14H); else pass_cnt++;
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b1111) $display("FAIL two_rows_g0_mask got=%b exp=1111", validSamp_R14H); else pass_cnt++;
        total_cnt++; if (sample_R14S[0] !== {24'd3072, 24'd2048, 24'd1024, 24'd0}) $display("FAIL two_rows_g0_x got=%h", sample_R14S[0]); else pass_cnt++;
        total_cnt++; if (sample_R14S[1] !== {4{24'd0}}) $display("FAIL two_rows_g0_y got=%h exp=0", sample_R14S[1]); else pass_cnt++;
        total_cnt++; if (halt_RnnnnL !== 1'b0) $display("FAIL two_rows_g0_halt got=%b exp=0", halt_RnnnnL); else pass_cnt++;
        total_cnt++; if (tri_R14S !== exp_tri || color_R14U !== {3{24'h000112}}) $display("FAIL two_rows_tri_color got=%h/%h", tri_R14S, color_R14U); else pass_cnt++;
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b1111) $display("FAIL two_rows_g1_mask got=%b exp=1111", validSamp_R14H); else pass_cnt++;
        total_cnt++; if (sample_R14S[1] !== {4{24'd1024}}) $display("FAIL two_rows_g1_y got=%h exp=1024s", sample_R14S[1]); else pass_cnt++;
        total_cnt++; if (sample_R14S[0] !== {24'd3072, 24'd2048, 24'd1024, 24'd0}) $display("FAIL two_rows_g1_x got=%h", sample_R14S[0]); else pass_cnt++;
        total_cnt++; if (halt_RnnnnL !== 1'b1) $display("FAIL two_rows_g1_halt got=%b exp=1", halt_RnnnnL); else pass_cnt++;
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b0000 || halt_RnnnnL !== 1'b1) $display("FAIL two_rows_idle valid=%b halt=%b exp=0000/1", validSamp_R14H, halt_RnnnnL); else pass_cnt++;
    endtask

    task automatic test_1x_narrow;
        drive_tri(24'd0, 24'd0, 24'd2048, 24'd0, 4'b1000, 24'h000222);
        tick;
        validTri_R13H = 1'b0;
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b0111) $display("FAIL narrow_mask got=%b exp=0111", validSamp_R14H); else pass_cnt++;
        total_cnt++; if (sample_R14S[0][2:0] !== {24'd2048, 24'd1024, 24'd0}) $display("FAIL narrow_x got=%h", sample_R14S[0]); else pass_cnt++;
        total_cnt++; if (halt_RnnnnL !== 1'b1) $display("FAIL narrow_halt got=%b exp=1", halt_RnnnnL); else pass_cnt++;
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b0000) $display("FAIL narrow_clear got=%b exp=0000", validSamp_R14H); else pass_cnt++;
    endtask

    task automatic test_4x;
        drive_tri(24'd512, 24'd512, 24'd1536, 24'd512, 4'b0100, 24'h000333);
        tick;
        validTri_R13H = 1'b0;
        tick;
        total_cnt++; if (sample_R14S[0] !== {24'd2048, 24'd1536, 24'd1024, 24'd512}) $display("FAIL msaa4_x got=%h", sample_R14S[0]); else pass_cnt++;
        total_cnt++; if (sample_R14S[1] !== {4{24'd512}}) $display("FAIL msaa4_y got=%h exp=512s", sample_R14S[1]); else pass_cnt++;
        total_cnt++; if (validSamp_R14H !== 4'b0111 || halt_RnnnnL !== 1'b1) $display("FAIL msaa4_mask mask=%b halt=%b exp=0111/1", validSamp_R14H, halt_RnnnnL); else pass_cnt++;
        tick;
    endtask

    task automatic test_stall;
        int sum;
        int rows;
        drive_tri(24'd0, 24'd0, 24'd3072, 24'd3072, 4'b1000, 24'h000444);
        tick;
        validTri_R13H = 1'b0;
        tick;
        sum  = $countones(validSamp_R14H);
        rows = 1;
        halt_in_RnnnnL = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            total_cnt++;
            if (validSamp_R14H !== 4'b1111 || sample_R14S[1][0] !== 24'd0 || halt_RnnnnL !== 1'b0)
                $display("FAIL stall_frozen cyc=%0d valid=%b y=%0d halt=%b exp=1111/0/0", k, validSamp_R14H, sample_R14S[1][0], halt_RnnnnL);
            else pass_cnt++;
        end
        halt_in_RnnnnL = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (validSamp_R14H !== 4'b0000) begin
                total_cnt++;
                if (sample_R14S[1][0] !== 24'(rows * 1024)) $display("FAIL stall_row_y got=%0d exp=%0d", sample_R14S[1][0], rows * 1024);
                else pass_cnt++;
                sum  = sum + $countones(validSamp_R14H);
                rows = rows + 1;
            end
            if (halt_RnnnnL === 1'b1) break;
        end
        total_cnt++; if (sum != 16) $display("FAIL stall_sample_sum got=%0d exp=16", sum); else pass_cnt++;
        total_cnt++; if (rows != 4 || halt_RnnnnL !== 1'b1) $display("FAIL stall_groups rows=%0d halt=%b exp=4/1", rows, halt_RnnnnL); else pass_cnt++;
        tick;
    endtask

    task automatic test_reset_mid;
        drive_tri(24'd0, 24'd0, 24'd3072, 24'd15360, 4'b1000, 24'h000555);
        tick;
        validTri_R13H = 1'b0;
        for (int k = 0; k < 5; k++) tick;
        total_cnt++; if (halt_RnnnnL !== 1'b0 || validSamp_R14H !== 4'b1111) $display("FAIL midrst_busy halt=%b valid=%b exp=0/1111", halt_RnnnnL, validSamp_R14H); else pass_cnt++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total_cnt++; if (validSamp_R14H !== 4'b0000 || halt_RnnnnL !== 1'b1) $display("FAIL midrst_state valid=%b halt=%b exp=0000/1", validSamp_R14H, halt_RnnnnL); else pass_cnt++;
        total_cnt++; if (sample_R14S !== '0 || tri_R14S !== '0) $display("FAIL midrst_outputs sample=%h tri=%h exp=0", sample_R14S, tri_R14S); else pass_cnt++;
        drive_tri(24'd1024, 24'd2048, 24'd1024, 24'd2048, 4'b1000, 24'h000666);
        tick;
        validTri_R13H = 1'b0;
        total_cnt++; if (halt_RnnnnL !== 1'b0) $display("FAIL degen_accept halt=%b exp=0", halt_RnnnnL); else pass_cnt++;
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b0001 || halt_RnnnnL !== 1'b1) $display("FAIL degen_mask mask=%b halt=%b exp=0001/1", validSamp_R14H, halt_RnnnnL); else pass_cnt++;
        total_cnt++; if (sample_R14S[0][0] !== 24'd1024 || sample_R14S[1][0] !== 24'd2048) $display("FAIL degen_xy got=%0d,%0d exp=1024,2048", sample_R14S[0][0], sample_R14S[1][0]); else pass_cnt++;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [8:0][23:0] tri_a;
        logic [8:0][23:0] tri_b;
        tri_a = {9{24'h000777}};
        tri_b = {9{24'h000888}};
        drive_tri(24'd0, 24'd0, 24'd1024, 24'd0, 4'b1000, 24'h000777);
        tick;
        drive_tri(24'd2048, 24'd1024, 24'd2048, 24'd1024, 4'b1000, 24'h000888);
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b0011 || halt_RnnnnL !== 1'b1) $display("FAIL b2b_a_mask mask=%b halt=%b exp=0011/1", validSamp_R14H, halt_RnnnnL); else pass_cnt++;
        total_cnt++; if (tri_R14S !== tri_a || sample_R14S[0][0] !== 24'd0) $display("FAIL b2b_a_tri tri=%h x0=%0d", tri_R14S[0][0], sample_R14S[0][0]); else pass_cnt++;
        tick;
        validTri_R13H = 1'b0;
        total_cnt++; if (halt_RnnnnL !== 1'b0 || validSamp_R14H !== 4'b0000) $display("FAIL b2b_b_accept halt=%b valid=%b exp=0/0000", halt_RnnnnL, validSamp_R14H); else pass_cnt++;
        tick;
        total_cnt++; if (validSamp_R14H !== 4'b0001 || halt_RnnnnL !== 1'b1) $display("FAIL b2b_b_mask mask=%b halt=%b exp=0001/1", validSamp_R14H, halt_RnnnnL); else pass_cnt++;
        total_cnt++; if (tri_R14S !== tri_b || sample_R14S[0][0] !== 24'd2048 || sample_R14S[1][0] !== 24'd1024) $display("FAIL b2b_b_data tri=%h x0=%0d y0=%0d", tri_R14S[0][0], sample_R14S[0][0], sample_R14S[1][0]); else pass_cnt++;
        tick;
    endtask

    initial begin
        rst              = 1'b1;
        tri_R13S         = '0;
        color_R13U       = '0;
        box_R13S         = '0;
        validTri_R13H    = 1'b0;
        subSample_RnnnnU = 4'b1000;
        halt_in_RnnnnL   = 1'b1;
        test_reset;
        test_1x_two_rows;
        test_1x_narrow;
        test_4x;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
